// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop), bit time DIV = round(CLK_FREQ/BAUD) clocks.
// Optional feature macro: UART_TX_CFG_PARITY_EN builds parity generation and
// the PARITY state; without it parity_mode is ignored and frames carry no parity.
// Ports:
//   clk         rising-edge clock
//   resetn      synchronous active-low reset
//   tx_valid    character available on tx_data
//   tx_ready    block can accept a character this cycle
//   tx_data     character, sent LSB first
//   parity_mode 00/11 none, 01 even, 10 odd (latched on acceptance)
//   tx          registered serial line, idle high
//   tx_busy     frame in progress
//   tx_done     one-cycle pulse on the last cycle of the final stop bit
module uart_tx_cfg #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_STOP = CW'(DIV - 2);
    localparam logic [3:0]    DBIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SBIT_LAST = 4'(STOP_BITS - 1);

`ifdef UART_TX_CFG_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed;

`ifdef UART_TX_CFG_PARITY_EN
    logic par_en;
    logic par_bit;
`else
    logic unused_mode;
    assign unused_mode = ^parity_mode;
`endif

    // armed is low only during the reset cycle(s), so ready is low in reset
    // and rises on the first cycle after release.
    assign tx_ready = armed && (state == IDLE);
    assign tx_busy  = armed && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
            par_en  <= 1'b0;
            par_bit <= 1'b0;
`endif
        end else begin
            armed   <= 1'b1;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state   <= START;
                        tx      <= 1'b0;
                        cnt     <= '0;
                        bit_idx <= '0;
                        shreg   <= tx_data;
`ifdef UART_TX_CFG_PARITY_EN
                        par_en  <= parity_mode[0] ^ parity_mode[1];
                        par_bit <= (^tx_data) ^ parity_mode[1];
`endif
                    end
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == DBIT_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_CFG_PARITY_EN
                            if (par_en) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_CFG_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leave one cycle early: the IDLE/tx_done cycle is the
                    // last stop cycle, so a same-cycle accept gives no gap.
                    if (bit_idx == SBIT_LAST && cnt == CNT_STOP) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_done <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg (DIV=4), one 8N1 instance
// and one 7-data/2-stop instance; expected line waveforms are queued per frame.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

    typedef struct {
        logic [63:0] wave;
        int          len;
        int          gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;

    logic       va = 1'b0;
    logic [7:0] da = '0;
    logic [1:0] ma = '0;
    logic       ra, txa, ba, dna;

    logic       vb = 1'b0;
    logic [6:0] db = '0;
    logic [1:0] mb = '0;
    logic       rb, txb, bb, dnb;

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .CLK_FREQ(1000000), .BAUD(250000)
    ) dut_a (
        .clk(clk), .resetn(resetn), .tx_valid(va), .tx_ready(ra),
        .tx_data(da), .parity_mode(ma), .tx(txa), .tx_busy(ba),
        .tx_done(dna)
    );

    uart_tx_cfg #(
        .CLK_FREQ(1000000), .BAUD(250000), .DATA_BITS(7), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .resetn(resetn), .tx_valid(vb), .tx_ready(rb),
        .tx_data(db), .parity_mode(mb), .tx(txb), .tx_busy(bb),
        .tx_done(dnb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic        in_f[2];
    int          cyc[2];
    int          idle[2];
    int          sgap[2];
    logic [63:0] wv[2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Frame given as line bits in transmit order, each lasting 4 clocks.
    function automatic exp_t mk(input string s, input int gap);
        exp_t e;
        e.wave = '0;
        e.len  = s.len() * 4;
        e.gap  = gap;
        for (int k = 0; k < s.len(); k++)
            for (int j = 0; j < 4; j++)
                e.wave[k*4+j] = (s.getc(k) == 8'h31);
        return e;
    endfunction

    task automatic mon_step(input int i, input logic t, input logic d);
        exp_t        e;
        logic [63:0] mask;
        if (!resetn) begin
            in_f[i] = 1'b0;
            idle[i] = 0;
            return;
        end
        if (!in_f[i] && t == 1'b0) begin
            in_f[i] = 1'b1;
            cyc[i]  = 0;
            wv[i]   = '0;
            sgap[i] = idle[i];
        end
        if (in_f[i]) begin
            if (cyc[i] < 64) wv[i][cyc[i]] = t;
            cyc[i]++;
        end
        if (d) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done%0d: got pulse want none", i);
            end else begin
                if (i == 0) e = q0.pop_front();
                else e = q1.pop_front();
                mask = (64'd1 << e.len) - 64'd1;
                chk($sformatf("wave%0d", i), wv[i] & mask, e.wave);
                chk($sformatf("len%0d", i), 64'(cyc[i]), 64'(e.len));
                if (e.gap >= 0)
                    chk($sformatf("gap%0d", i), 64'(sgap[i]), 64'(e.gap));
            end
            in_f[i] = 1'b0;
            idle[i] = 0;
        end else if (!in_f[i]) begin
            idle[i]++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_f[i] = 1'b0;
            cyc[i]  = 0;
            idle[i] = 0;
            sgap[i] = 0;
            wv[i]   = '0;
        end
    end

    always @(negedge clk) begin
        mon_step(0, txa, dna);
        mon_step(1, txb, dnb);
    end

    task automatic send_a(input logic [7:0] d, input logic [1:0] m,
                          input bit keep);
        int t = 0;
        va = 1'b1;
        da = d;
        ma = m;
        while (ra !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_a", ra, 1);
        @(posedge clk);
        #1;
        if (!keep) va = 1'b0;
        @(negedge clk);
        chk("start_a", txa, 0);
        chk("busy_a", ba, 1);
    endtask

    task automatic send_b(input logic [6:0] d);
        int t = 0;
        vb = 1'b1;
        db = d;
        while (rb !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_b", rb, 1);
        @(posedge clk);
        #1;
        vb = 1'b0;
        @(negedge clk);
        chk("start_b", txb, 0);
    endtask

    task automatic wait_done_a();
        int t = 0;
        while (dna !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done_a seen", dna, 1);
        chk("ready_at_done_a", ra, 1);
        @(negedge clk);
    endtask

    task automatic wait_done_b();
        int t = 0;
        while (dnb !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done_b seen", dnb, 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_a", txa, 1);
        chk("rst_ready_a", ra, 0);
        chk("rst_busy_a", ba, 0);
        chk("rst_done_a", dna, 0);
        chk("rst_tx_b", txb, 1);
        chk("rst_ready_b", rb, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_ready_a", ra, 1);
        chk("rel_busy_a", ba, 0);

        q0.push_back(mk("0101010101", -1));
        send_a(8'h55, 2'b00, 0);
        wait_done_a();

`ifdef UART_TX_CFG_PARITY_EN
        q0.push_back(mk("01110000011", -1));
        q0.push_back(mk("01110000001", -1));
`else
        q0.push_back(mk("0111000001", -1));
        q0.push_back(mk("0111000001", -1));
`endif
        send_a(8'h07, 2'b01, 0);
        wait_done_a();
        send_a(8'h07, 2'b10, 0);
        repeat (6) @(negedge clk);
        da = 8'hFF;
        ma = 2'b00;
        wait_done_a();

        q0.push_back(mk("0101010101", -1));
        send_a(8'h55, 2'b11, 0);
        wait_done_a();

        q0.push_back(mk("0101001011", -1));
        q0.push_back(mk("0001111001", 0));
        send_a(8'hA5, 2'b00, 1);
        da = 8'h3C;
        send_a(8'h3C, 2'b00, 0);
        wait_done_a();

        q1.push_back(mk("0111111111", -1));
        send_b(7'h7F);
        repeat (8) @(negedge clk);
        db = 7'h00;
        wait_done_b();
        q1.push_back(mk("0010101011", -1));
        send_b(7'h2A);
        wait_done_b();

        send_a(8'h55, 2'b00, 0);
        repeat (14) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_tx_a", txa, 1);
        chk("abort_ready_a", ra, 0);
        chk("abort_busy_a", ba, 0);
        chk("abort_done_a", dna, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rerel_ready_a", ra, 1);
        q0.push_back(mk("0101010101", -1));
        send_a(8'h55, 2'b00, 0);
        wait_done_a();

        repeat (5) @(negedge clk);
        chk("q0_empty", 64'(q0.size()), 0);
        chk("q1_empty", 64'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
